// File: rtl/nrs_gold_seq_gen_tx.sv
// -----------------------------------------------------------------------------
// nrs_gold_seq_gen_tx
//
// Gold pseudo-random sequence generator for the NB-IoT narrowband reference
// signal (NRS). From the cell ID, slot number and OFDM symbol index it forms
// c_init, seeds the two 31-bit LFSRs (x1 fixed to 1, x2 to c_init), advances
// both by NC + M_OFFSET steps and then captures the four sequence bits
// c(218), c(219), c(220), c(221). These feed the downstream NRS QPSK mapping
// (c = 1 -> -0.707, c = 0 -> +0.707).
//
// Ports
//   clk         in   1  system clock, rising edge
//   rst_n       in   1  asynchronous active-low reset
//   start       in   1  request a generation; only looked at while idle
//   n_id_ncell  in   9  NB-IoT cell ID, 0..503
//   ns          in   5  slot number, 0..19
//   l           in   3  OFDM symbol index within the slot, 0..6
//   busy        out  1  high from the accepting edge through the capture edge
//   c_valid     out  1  single-cycle pulse, c0..c3 have just been updated
//   c0..c3      out  1  c(M_OFFSET) .. c(M_OFFSET+3), held until next capture
//
// Timing, counting edges from the one that accepts start (E0):
//   E1          seed the LFSRs
//   E2..E1819   1818 shift steps
//   E1820       capture, c_valid high in the following cycle
//   E1821       earliest next accept (start may simply be held high)
// -----------------------------------------------------------------------------
module nrs_gold_seq_gen_tx #(
    parameter int NC       = 1600,
    parameter int M_OFFSET = 218
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [8:0] n_id_ncell,
    input  logic [4:0] ns,
    input  logic [2:0] l,
    output logic       busy,
    output logic       c_valid,
    output logic       c0,
    output logic       c1,
    output logic       c2,
    output logic       c3
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int          N_SHIFT  = NC + M_OFFSET;
    // The ADV state leaves when the count of completed shifts is about to
    // reach N_SHIFT; an 11-bit counter covers this without wrapping.
    localparam logic [10:0] CNT_LAST = 11'(N_SHIFT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_ADV     = 2'd2,
        ST_CAPTURE = 2'd3
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e      state_q,   state_d;
    logic        busy_q,    busy_d;
    logic        c_valid_q, c_valid_d;
    logic [3:0]  c_q,       c_d;
    logic [30:0] x1_q,      x1_d;
    logic [30:0] x2_q,      x2_d;
    logic [10:0] cnt_q,     cnt_d;

    // Request parameters, frozen at accept so that input changes during a
    // run cannot disturb the seed.
    logic [8:0]  n_id_q,    n_id_d;
    logic [4:0]  ns_q,      ns_d;
    logic [2:0]  l_q,       l_d;

    // -------------------------------------------------------------------------
    // c_init = 2^10 * (7*(ns+1) + l + 1) * (2*n_id + 1) + 2*n_id + 1
    //
    // slot_term fits 8 bits even for out-of-range ns/l (max 7*32+8 = 232),
    // id_term is 10 bits, their product 18 bits, shifted 28 bits, and the
    // final sum 31 bits. Nothing is clamped.
    // -------------------------------------------------------------------------
    logic [7:0]  ns_plus1;
    logic [7:0]  slot_term;
    logic [9:0]  id_term;
    logic [17:0] seed_prod;
    logic [30:0] c_init;

    always_comb begin
        ns_plus1  = {3'b000, ns_q} + 8'd1;
        slot_term = (ns_plus1 * 8'd7) + {5'b00000, l_q} + 8'd1;
        id_term   = {n_id_q, 1'b1};
        seed_prod = {10'd0, slot_term} * {8'd0, id_term};
        c_init    = {3'b000, seed_prod, 10'd0} + {21'd0, id_term};
    end

    // -------------------------------------------------------------------------
    // LFSR single steps. Bit k holds x(n+k); a step drops x(n) off bit 0 and
    // appends x(n+31) at bit 30.
    //   x1(n+31) = x1(n+3) ^ x1(n)
    //   x2(n+31) = x2(n+3) ^ x2(n+2) ^ x2(n+1) ^ x2(n)
    // -------------------------------------------------------------------------
    logic [30:0] x1_step;
    logic [30:0] x2_step;

    always_comb begin
        x1_step = {x1_q[3] ^ x1_q[0], x1_q[30:1]};
        x2_step = {x2_q[3] ^ x2_q[2] ^ x2_q[1] ^ x2_q[0], x2_q[30:1]};
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d   = state_q;
        busy_d    = busy_q;
        c_valid_d = 1'b0;          // pulse: drops on the edge after capture
        c_d       = c_q;
        x1_d      = x1_q;
        x2_d      = x2_q;
        cnt_d     = cnt_q;
        n_id_d    = n_id_q;
        ns_d      = ns_q;
        l_d       = l_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_id_d  = n_id_ncell;
                    ns_d    = ns;
                    l_d     = l;
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                x1_d    = 31'd1;
                x2_d    = c_init;
                cnt_d   = 11'd0;
                state_d = ST_ADV;
            end

            ST_ADV: begin
                x1_d  = x1_step;
                x2_d  = x2_step;
                cnt_d = cnt_q + 11'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_CAPTURE;
                end
            end

            ST_CAPTURE: begin
                // After N_SHIFT steps bit k of each register holds
                // x(NC + M_OFFSET + k), so c(M_OFFSET + k) = x1[k] ^ x2[k].
                c_d       = x1_q[3:0] ^ x2_q[3:0];
                c_valid_d = 1'b1;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: the LFSRs, counter and captured bits are reset along with the
    // control state; a reset mid-run must leave no stale result visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            c_valid_q <= 1'b0;
            c_q       <= 4'd0;
            x1_q      <= 31'd0;
            x2_q      <= 31'd0;
            cnt_q     <= 11'd0;
            n_id_q    <= 9'd0;
            ns_q      <= 5'd0;
            l_q       <= 3'd0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // values from before this edge regardless of statement order.
            state_q   <= state_d;
            busy_q    <= busy_d;
            c_valid_q <= c_valid_d;
            c_q       <= c_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            cnt_q     <= cnt_d;
            n_id_q    <= n_id_d;
            ns_q      <= ns_d;
            l_q       <= l_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy    = busy_q;
    assign c_valid = c_valid_q;
    assign c0      = c_q[0];
    assign c1      = c_q[1];
    assign c2      = c_q[2];
    assign c3      = c_q[3];

endmodule

// File: tb/tb_nrs_gold_seq_gen_tx.sv
// -----------------------------------------------------------------------------
// tb_nrs_gold_seq_gen_tx
//
// Bench for nrs_gold_seq_gen_tx. Expected c(218..221) come from a direct
// array-based evaluation of the Gold sequence recurrences; they are queued
// when a request is accepted and popped when c_valid is observed.
// Inputs change on the falling edge, outputs are sampled 1 ns after rising.
// -----------------------------------------------------------------------------
module tb_nrs_gold_seq_gen_tx;

    localparam int LAT     = 1820;   // rising edges from accept to c_valid
    localparam int TIMEOUT = 2500;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [8:0] n_id_ncell;
    logic [4:0] ns;
    logic [2:0] l;
    logic       busy, c_valid, c0, c1, c2, c3;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] sb_q[$];

    nrs_gold_seq_gen_tx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .n_id_ncell (n_id_ncell),
        .ns         (ns),
        .l          (l),
        .busy       (busy),
        .c_valid    (c_valid),
        .c0         (c0),
        .c1         (c1),
        .c2         (c2),
        .c3         (c3)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------ model
    function automatic logic [30:0] model_cinit(int n_id, int s, int sym);
        longint v;
        v = 64'd1024 * longint'(7 * (s + 1) + sym + 1) * longint'(2 * n_id + 1)
            + longint'(2 * n_id + 1);
        return v[30:0];
    endfunction

    function automatic logic [3:0] model_c(int n_id, int s, int sym);
        logic [30:0] ci;
        bit          x1[1822];
        bit          x2[1822];
        logic [3:0]  r;
        ci = model_cinit(n_id, s, sym);
        for (int i = 0; i < 31; i++) begin
            x1[i] = (i == 0);
            x2[i] = ci[i];
        end
        for (int i = 31; i < 1822; i++) begin
            x1[i] = x1[i-28] ^ x1[i-31];
            x2[i] = x2[i-28] ^ x2[i-29] ^ x2[i-30] ^ x2[i-31];
        end
        for (int k = 0; k < 4; k++) r[k] = x1[1600 + 218 + k] ^ x2[1600 + 218 + k];
        return r;
    endfunction

    // ---------------------------------------------------------------- helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request on the falling edge, queue its expected result and
    // return just after the accepting edge E0.
    task automatic issue(input int n_id, input int s, input int sym, input bit hold);
        @(negedge clk);
        n_id_ncell = 9'(n_id);
        ns         = 5'(s);
        l          = 3'(sym);
        start      = 1'b1;
        sb_q.push_back(model_c(n_id, s, sym));
        tick();
        if (!hold) start = 1'b0;
    endtask

    // Count rising edges until c_valid is seen, bounded by TIMEOUT.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (c_valid !== 1'b1 && cyc < TIMEOUT) begin
            tick();
            cyc++;
        end
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        n_id_ncell = '0;
        ns = '0;
        l = '0;
        #1;
        n_cmp++;
        if ({busy, c_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_ctrl: busy,c_valid got %b expected 00", {busy, c_valid});
        end
        n_cmp++;
        if ({c3, c2, c1, c0} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_c: c3..c0 got %b expected 0000", {c3, c2, c1, c0});
        end
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Single request: latency, busy, seed and result.
    task automatic test_single(input string name, input int n_id, input int s, input int sym);
        int         cyc;
        logic [3:0] exp_c;
        issue(n_id, s, sym, 1'b0);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_busy: got %b expected 1", name, busy);
        end
        n_cmp++;
        if (dut.c_init !== model_cinit(n_id, s, sym)) begin
            n_bad++;
            $display("FAIL %s_cinit: got %0d expected %0d", name, dut.c_init,
                     model_cinit(n_id, s, sym));
        end
        wait_valid(cyc);
        n_cmp++;
        if (cyc !== LAT) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d expected %0d", name, cyc, LAT);
        end
        exp_c = sb_q.pop_front();
        n_cmp++;
        if ({c3, c2, c1, c0} !== exp_c) begin
            n_bad++;
            $display("FAIL %s_c: c3..c0 got %b expected %b", name, {c3, c2, c1, c0}, exp_c);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_busy_end: got %b expected 0", name, busy);
        end
        tick();
        n_cmp++;
        if (c_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_pulse: c_valid got %b one cycle later, expected 0", name, c_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        // Abort mid-ADV.
        issue(77, 4, 5, 1'b0);
        repeat (500) tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, c_valid, c3, c2, c1, c0} !== 6'b0) begin
            n_bad++;
            $display("FAIL rst_adv: busy,c_valid,c3..c0 got %b expected 000000",
                     {busy, c_valid, c3, c2, c1, c0});
        end
        sb_q.delete();
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            tick();
            if (c_valid === 1'b1 || busy === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL rst_quiet: activity cycles after reset got %0d expected 0", seen);
        end
        // Abort in the CAPTURE cycle, before the capturing edge.
        issue(300, 12, 6, 1'b0);
        repeat (LAT - 1) tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, c_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_capture: busy,c_valid got %b expected 00", {busy, c_valid});
        end
        sb_q.delete();
        tick();
        tick();
        n_cmp++;
        if ({c_valid, c3, c2, c1, c0} !== 5'b0) begin
            n_bad++;
            $display("FAIL rst_capture_nopulse: c_valid,c3..c0 got %b expected 00000",
                     {c_valid, c3, c2, c1, c0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_single("rst_rerun", 300, 12, 6);
    endtask

    task automatic test_sweep();
        int pts[10][3] = '{'{0, 0, 6}, '{503, 0, 5}, '{0, 19, 6}, '{503, 19, 5},
                           '{1, 1, 5}, '{250, 10, 6}, '{411, 7, 5}, '{2, 18, 6},
                           '{0, 0, 0}, '{0, 0, 0}};
        for (int i = 8; i < 10; i++) begin
            pts[i][0] = int'($urandom_range(503, 0));
            pts[i][1] = int'($urandom_range(19, 0));
            pts[i][2] = int'($urandom_range(6, 5));
        end
        for (int i = 0; i < 10; i++) begin
            test_single($sformatf("sweep%0d", i), pts[i][0], pts[i][1], pts[i][2]);
        end
    endtask

    task automatic test_busy_ignore();
        int         cyc;
        int         seen;
        logic [3:0] exp_c;
        issue(100, 3, 5, 1'b0);
        repeat (799) tick();
        @(negedge clk);
        n_id_ncell = 9'd400;
        ns         = 5'd17;
        l          = 3'd6;
        start      = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(cyc);
        n_cmp++;
        if (cyc + 800 !== LAT) begin
            n_bad++;
            $display("FAIL ignore_latency: got %0d expected %0d", cyc + 800, LAT);
        end
        exp_c = sb_q.pop_front();
        n_cmp++;
        if ({c3, c2, c1, c0} !== exp_c) begin
            n_bad++;
            $display("FAIL ignore_c: c3..c0 got %b expected %b", {c3, c2, c1, c0}, exp_c);
        end
        seen = 0;
        repeat (6) begin
            tick();
            if (busy === 1'b1 || c_valid === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL ignore_no_rerun: activity cycles got %0d expected 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int         cyc;
        logic [3:0] exp_c;
        issue(503, 19, 6, 1'b1);
        sb_q.push_back(model_c(503, 19, 6));
        sb_q.push_back(model_c(503, 19, 6));
        for (int r = 0; r < 3; r++) begin
            wait_valid(cyc);
            if (r == 2) start = 1'b0;
            n_cmp++;
            if (cyc !== LAT) begin
                n_bad++;
                $display("FAIL b2b%0d_spacing: got %0d expected %0d", r, cyc, LAT);
            end
            exp_c = sb_q.pop_front();
            n_cmp++;
            if ({c3, c2, c1, c0} !== exp_c) begin
                n_bad++;
                $display("FAIL b2b%0d_c: c3..c0 got %b expected %b", r, {c3, c2, c1, c0}, exp_c);
            end
            n_cmp++;
            if (busy !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b%0d_gap: busy got %b expected 0", r, busy);
            end
            tick();
            n_cmp++;
            if ({busy, c_valid} !== ((r < 2) ? 2'b10 : 2'b00)) begin
                n_bad++;
                $display("FAIL b2b%0d_next: busy,c_valid got %b expected %b", r,
                         {busy, c_valid}, (r < 2) ? 2'b10 : 2'b00);
            end
        end
    endtask

    // ------------------------------------------------------------------- main
    initial begin
        test_reset();
        test_single("min", 0, 0, 5);
        test_single("max", 503, 19, 6);
        test_reset_mid_run();
        test_sweep();
        test_busy_ignore();
        test_back_to_back();
        n_cmp++;
        if (sb_q.size() !== 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: entries left got %0d expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
